// File: rtl/bus_target_decoder_if.sv
// Initiator-side request/ready bus plus the four-port device fan-out of the target decoder.
// slave = decoder view; master = initiator/device-model view.
interface bus_target_decoder_if;
  logic         i_bus_rw;
  logic         i_bus_request;
  logic         o_bus_ready;
  logic [31:0]  i_bus_address;
  logic [31:0]  o_bus_rdata;
  logic [31:0]  i_bus_wdata;
  logic         o_error;
  logic [3:0]   o_dev_request;
  logic [3:0]   i_dev_ready;
  logic         o_dev_rw;
  logic [31:0]  o_dev_address;
  logic [31:0]  o_dev_wdata;
  logic [127:0] i_dev_rdata;

  modport slave (
    input  i_bus_rw, i_bus_request, i_bus_address, i_bus_wdata, i_dev_ready, i_dev_rdata,
    output o_bus_ready, o_bus_rdata, o_error, o_dev_request, o_dev_rw, o_dev_address, o_dev_wdata
  );

  modport master (
    output i_bus_rw, i_bus_request, i_bus_address, i_bus_wdata, i_dev_ready, i_dev_rdata,
    input  o_bus_ready, o_bus_rdata, o_error, o_dev_request, o_dev_rw, o_dev_address, o_dev_wdata
  );
endinterface

// File: rtl/bus_target_decoder.sv
// Bus target decoder: one transaction at a time, address[31:28] selects one of four device ports; ready 2 cycles
// after request on a hit (1 on a miss); waits on device ready. BUS_TARGET_TIMEOUT_EN adds a forced-error timeout.
module bus_target_decoder #(
  parameter logic [3:0]  P0_REGION     = 4'h0,
  parameter logic [3:0]  P1_REGION     = 4'h1,
  parameter logic [3:0]  P2_REGION     = 4'h2,
  parameter logic [3:0]  P3_REGION     = 4'h5,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  bus_target_decoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  port_q, port_d;
  logic [3:0]  dev_req_q, dev_req_d;
  logic        dev_rw_q, dev_rw_d;
  logic [31:0] dev_addr_q, dev_addr_d;
  logic [31:0] dev_wdata_q, dev_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        hit;
  logic [1:0]  hit_port;

`ifdef BUS_TARGET_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  // Lowest-indexed matching region wins when regions overlap.
  always_comb begin
    hit      = 1'b1;
    hit_port = 2'd0;
    if (bus.i_bus_address[31:28] == P0_REGION)      hit_port = 2'd0;
    else if (bus.i_bus_address[31:28] == P1_REGION) hit_port = 2'd1;
    else if (bus.i_bus_address[31:28] == P2_REGION) hit_port = 2'd2;
    else if (bus.i_bus_address[31:28] == P3_REGION) hit_port = 2'd3;
    else                                            hit      = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    dev_req_d   = dev_req_q;
    dev_rw_d    = dev_rw_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
`ifdef BUS_TARGET_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_bus_request) begin
          dev_rw_d    = bus.i_bus_rw;
          dev_addr_d  = bus.i_bus_address;
          dev_wdata_d = bus.i_bus_wdata;
          if (hit) begin
            port_d    = hit_port;
            dev_req_d = 4'b0001 << hit_port;
            state_d   = ACCESS;
`ifdef BUS_TARGET_TIMEOUT_EN
            cnt_d     = 16'd0;
`endif
          end else begin
            rdata_d = UNMAPPED_DATA;
            error_d = 1'b1;
            state_d = RESPOND;
          end
        end
      end
      ACCESS: begin
        // Read data is captured on writes as well; the device decides what it drives.
        if (bus.i_dev_ready[port_q]) begin
          rdata_d   = bus.i_dev_rdata[{port_q, 5'd0} +: 32];
          dev_req_d = 4'b0000;
          state_d   = RESPOND;
        end
`ifdef BUS_TARGET_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d   = UNMAPPED_DATA;
          dev_req_d = 4'b0000;
          error_d   = 1'b1;
          state_d   = RESPOND;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESPOND: state_d = RELEASE;
      RELEASE: if (!bus.i_bus_request) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The ready strobe is registered, so it rises on the edge that enters RESPOND.
    ready_d = (state_d == RESPOND) && (state_q != RESPOND);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      port_q      <= 2'd0;
      dev_req_q   <= 4'b0000;
      dev_rw_q    <= 1'b0;
      dev_addr_q  <= 32'd0;
      dev_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
`ifdef BUS_TARGET_TIMEOUT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      dev_req_q   <= dev_req_d;
      dev_rw_q    <= dev_rw_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
`ifdef BUS_TARGET_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.o_bus_ready   = ready_q;
  assign bus.o_bus_rdata   = rdata_q;
  assign bus.o_error       = error_q;
  assign bus.o_dev_request = dev_req_q;
  assign bus.o_dev_rw      = dev_rw_q;
  assign bus.o_dev_address = dev_addr_q;
  assign bus.o_dev_wdata   = dev_wdata_q;

endmodule

// File: tb/tb_bus_target_decoder.sv
// Randomized bench for bus_target_decoder against a transaction-level reference model.
module tb_bus_target_decoder;
  localparam int TB_TIMEOUT = 8;
  localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_target_decoder_if bus ();

  bus_target_decoder #(.TIMEOUT(TB_TIMEOUT)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode: first region in the map (lowest port) that matches the top nibble.
  function automatic int ref_port(input logic [31:0] a);
    logic [3:0] regions [4];
    int r;
    regions = '{4'h0, 4'h1, 4'h2, 4'h5};
    r = -1;
    for (int k = 3; k >= 0; k--) if (a[31:28] == regions[k]) r = k;
    return r;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.o_bus_ready), 32'd0);
    check({tag, "_rdata"}, bus.o_bus_rdata, 32'd0);
    check({tag, "_error"}, 32'(bus.o_error), 32'd0);
    check({tag, "_devreq"}, 32'(bus.o_dev_request), 32'd0);
    check({tag, "_devrw"}, 32'(bus.o_dev_rw), 32'd0);
    check({tag, "_devaddr"}, bus.o_dev_address, 32'd0);
    check({tag, "_devwdata"}, bus.o_dev_wdata, 32'd0);
  endtask

  // rdy_cyc: ACCESS cycle (1-based) in which the selected device raises ready.
  task automatic run_txn(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                         input int rdy_cyc, input logic [31:0] rd);
    int          port, exp_req, exp_at, req_cnt, stray, rdy_at, c, bad;
    logic        exp_err, obs_err;
    logic [31:0] exp_rd, obs_rd;
    logic [3:0]  onehot, r;
    logic [127:0] rdv;

    port = ref_port(addr);
    if (port < 0) begin
      onehot = 4'b0000; exp_req = 0; exp_at = 1; exp_err = 1'b1; exp_rd = UNMAPPED;
    end else begin
      onehot = 4'b0001 << port; exp_req = rdy_cyc; exp_err = 1'b0; exp_rd = rd;
`ifdef BUS_TARGET_TIMEOUT_EN
      if (rdy_cyc > TB_TIMEOUT) begin
        exp_req = TB_TIMEOUT; exp_err = 1'b1; exp_rd = UNMAPPED;
      end
`endif
      exp_at = exp_req + 1;
    end
    rdv = {$urandom, $urandom, $urandom, $urandom};
    if (port >= 0) rdv[32*port +: 32] = rd;

    @(negedge clk);
    bus.i_bus_request = 1'b1;
    bus.i_bus_rw      = rw;
    bus.i_bus_address = addr;
    bus.i_bus_wdata   = wd;
    bus.i_dev_rdata   = rdv;
    bus.i_dev_ready   = 4'b0000;
    req_cnt = 0; stray = 0; rdy_at = 0; c = 0; obs_err = 1'b0; obs_rd = 32'd0;
    while (rdy_at == 0 && c < 3000) begin
      @(negedge clk);
      c++;
      if (onehot != 4'b0000 && bus.o_dev_request == onehot) req_cnt++;
      else if (bus.o_dev_request != 4'b0000) stray++;
      if (bus.o_bus_ready) begin
        rdy_at = c; obs_err = bus.o_error; obs_rd = bus.o_bus_rdata;
      end
      // Bus inputs change freely once sampled; other ports' ready bits are noise.
      bus.i_bus_address = $urandom;
      bus.i_bus_wdata   = $urandom;
      bus.i_bus_rw      = 1'($urandom);
      r = 4'($urandom);
      if (port >= 0)
        r[port] = (rdy_at == 0) && (bus.o_dev_request == onehot) && (req_cnt >= rdy_cyc);
      bus.i_dev_ready = r;
    end
    check("ready_cycle", 32'(rdy_at), 32'(exp_at));
    check("req_cycles", 32'(req_cnt), 32'(exp_req));
    check("stray_req", 32'(stray), 32'd0);
    check("error", 32'(obs_err), 32'(exp_err));
    check("rdata", obs_rd, exp_rd);
    check("dev_addr", bus.o_dev_address, addr);
    check("dev_wdata", bus.o_dev_wdata, wd);
    check("dev_rw", 32'(bus.o_dev_rw), 32'(rw));

    bad = 0;
    bus.i_dev_ready = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_bus_ready || bus.o_dev_request != 4'b0000) bad++;
    end
    check("held_req_no_restart", 32'(bad), 32'd0);
    check("rdata_hold", bus.o_bus_rdata, exp_rd);
    bus.i_bus_request = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  nib_tbl [8];
    logic [31:0] a;
    int          w;

    nib_tbl = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h3, 4'h4, 4'hF, 4'h9};
    rst_n = 1'b0;
    bus.i_bus_rw = 1'b0; bus.i_bus_request = 1'b0;
    bus.i_bus_address = 32'd0; bus.i_bus_wdata = 32'd0;
    bus.i_dev_ready = 4'b0000; bus.i_dev_rdata = '0;
    #22;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(32'h2000_0010, 1'b1, 32'h1234_5678, 3, $urandom);
    run_txn(32'h0000_0004, 1'b0, $urandom, 1, 32'hCAFE_BABE);
    run_txn(32'hF000_0000, 1'b0, $urandom, 1, $urandom);
    run_txn(32'h1000_0000, 1'b0, $urandom, 20, $urandom);
    run_txn(32'h5000_0100, 1'b0, $urandom, TB_TIMEOUT, $urandom);
    run_txn(32'h2000_0200, 1'b1, $urandom, TB_TIMEOUT + 1, $urandom);

    // Device 1 never answers, then reset lands between clock edges mid-ACCESS.
`ifdef BUS_TARGET_TIMEOUT_EN
    w = 5;
`else
    w = 1000;
`endif
    @(negedge clk);
    bus.i_bus_request = 1'b1; bus.i_bus_rw = 1'b0;
    bus.i_bus_address = 32'h1000_0040; bus.i_dev_ready = 4'b0000;
    repeat (w) @(negedge clk);
    check("stuck_req", 32'(bus.o_dev_request), 32'h2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    bus.i_bus_request = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h5000_0000, 1'b0, $urandom, 2, 32'h0BAD_F00D);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      a[31:28] = nib_tbl[$urandom_range(0, 7)];
      run_txn(a, 1'($urandom), $urandom, $urandom_range(1, 12), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_target_decoder.md
Name: bus_target_decoder

Overview:
- Responder end of the single-initiator request/ready system bus driven by the CPU-side port arbiter.
- Accepts one transaction at a time and decodes the address's top nibble to one of four downstream device ports.
- Forwards the access to the selected device and returns registered read data with a one-cycle ready.
- Answers unmapped or unresponsive accesses with a fixed data word and an error flag, so the initiator never hangs.

Parameters:
- P0_REGION, 4'h0, address[31:28] value selecting device port 0
- P1_REGION, 4'h1, address[31:28] value selecting device port 1
- P2_REGION, 4'h2, address[31:28] value selecting device port 2
- P3_REGION, 4'h5, address[31:28] value selecting device port 3
- UNMAPPED_DATA, 32'hDEAD_BEEF, read data returned on unmapped access or timeout
- TIMEOUT, 255, maximum ACCESS cycles before a forced error response (1..65535)

Ports:
- i_clock  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_bus_rw  in  1  1 = write, 0 = read
- i_bus_request  in  1  transaction request from the initiator
- o_bus_ready  out  1  one-cycle completion strobe
- i_bus_address  in  32  address
- o_bus_rdata  out  32  registered read data
- i_bus_wdata  in  32  write data
- o_error  out  1  high with o_bus_ready when the response is unmapped or timed out
- o_dev_request  out  4  one-hot request to device ports
- i_dev_ready  in  4  per-device ready
- o_dev_rw  out  1  latched rw
- o_dev_address  out  32  latched address
- o_dev_wdata  out  32  latched write data
- i_dev_rdata  in  128  device k read data at bits [32k+31:32k]

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset takes effect immediately, without a clock edge, including mid-transaction.
- IDLE, on an edge with i_bus_request=1:
  - Latch rw, address and wdata onto the o_dev_* outputs.
  - Decode address[31:28] against P0..P3. If several regions match, the lowest index wins.
  - Hit on port k: set o_dev_request = 1<<k, clear the counter, go to ACCESS.
  - Miss: o_dev_request stays 0; load o_bus_rdata = UNMAPPED_DATA, set the error flag, go to RESPOND.
- ACCESS:
  - o_dev_request[k] is held and the o_dev_* outputs stay stable.
  - Only i_dev_ready[k] is considered; other ready bits are ignored.
  - If i_dev_ready[k]=1: capture the rdata slice k (for writes too), clear o_dev_request, clear the error flag, go to RESPOND.
  - Otherwise the counter increments.
  - Timeout: when the counter reaches TIMEOUT-1 without ready, clear o_dev_request, load UNMAPPED_DATA, set the error flag, go to RESPOND. The request is therefore held for exactly TIMEOUT cycles.
- RESPOND: o_bus_ready=1 and o_error = error flag for exactly one cycle, then go to RELEASE.
- RELEASE: o_bus_ready=0; stay until i_bus_request=0 is sampled, then go to IDLE. A request held high continuously never starts a second transaction.
- Latency:
  - Request sampled at edge E0; a device ready on the first ACCESS cycle gives o_bus_ready high in the cycle after E1, i.e. 2 cycles after E0.
  - Unmapped access: o_bus_ready in the cycle after E0.
- o_bus_rdata holds its value until the next capture.
- o_dev_* outputs hold their last values after completion.
- i_bus_* inputs are ignored outside IDLE.

Optional Feature:
- Macro BUS_TARGET_TIMEOUT_EN.
- Defined: timeout counter and forced error response as described above.
- Undefined: no counter logic; ACCESS waits indefinitely for i_dev_ready[k]; TIMEOUT is unused; o_error asserts only for unmapped accesses.

Test Plan:
- Write to 0x2000_0010 with wdata 0x1234_5678; dev 2 ready after 3 ACCESS cycles -> o_dev_request=4'b0100 for 3 cycles with o_dev_wdata=0x1234_5678 and o_dev_rw=1; then o_bus_ready for 1 cycle; o_error=0.
- Read 0x0000_0004; dev 0 ready immediately with rdata 0xCAFE_BABE -> o_bus_rdata=0xCAFE_BABE, o_bus_ready 2 cycles after the request is sampled; i_dev_ready[1] asserted concurrently has no effect.
- Read 0xF000_0000 -> o_dev_request stays 0; next cycle o_bus_ready=1, o_bus_rdata=0xDEAD_BEEF, o_error=1.
- With BUS_TARGET_TIMEOUT_EN and TIMEOUT=8, dev 1 never ready -> o_dev_request=4'b0010 for exactly 8 cycles, then o_bus_ready=1, o_error=1, rdata 0xDEAD_BEEF. Without the macro -> request still held after 1000 cycles.
- i_reset_n driven low mid-ACCESS between clock edges -> all outputs 0 immediately; after release, a read from port 3 (0x5000_0000) completes normally.
- i_bus_request kept high after o_bus_ready -> no new o_dev_request; drop the request for 1 cycle and raise it again -> a new transaction starts.
